ring_counter: RTL and testbench



---
 rtl/ring_counter.sv | 55 +++++
 tb/tb_ring_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ring_counter.sv
// Rotating ring of WIDTH flip-flops that can be cleared or preset asynchronously, with complementary outputs.
// Defining RING_COUNTER_SELF_START_EN makes an all-zero ring load 0001 on the next clock edge.
module ring_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pre1,
  input  logic             pre_234,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);

  // FF1 and FF2..FFn are split because they have different asynchronous presets.
  logic             q0;
  logic [WIDTH-1:1] q_hi;
  logic [WIDTH-1:0] rot_c;
  logic             seed_c;

  assign Q     = {q_hi, q0};
  assign Qbar  = ~Q;
  assign rot_c = {Q[WIDTH-2:0], Q[WIDTH-1]};

`ifdef RING_COUNTER_SELF_START_EN
  // An all-zero ring would otherwise never recover.
  assign seed_c = (Q == '0) && !pre_234;
`else
  assign seed_c = 1'b0;
`endif

  // FF1: clear takes priority over preset, and both take priority over the shift.
  always_ff @(posedge clk or posedge rst or posedge pre1) begin
    if (rst) begin
      q0 <= 1'b0;
    end else if (pre1) begin
      q0 <= 1'b1;
    end else if (seed_c) begin
      q0 <= 1'b1;
    end else begin
      q0 <= rot_c[0];
    end
  end

  // FF2..FFn each load the bit before them.
  always_ff @(posedge clk or posedge rst or posedge pre_234) begin
    if (rst) begin
      q_hi <= '0;
    end else if (pre_234) begin
      q_hi <= '1;
    end else begin
      q_hi <= rot_c[WIDTH-1:1];
    end
  end

endmodule

// File: tb/tb_ring_counter.sv
// Directed checks of ring_counter: reset, presets, rotation, priority and the lock-up behaviour.
// If the DUT is built with RING_COUNTER_SELF_START_EN, this bench must be built with it too.
module tb_ring_counter;

  logic       clk;
  logic       rst;
  logic       pre1;
  logic       pre_234;
  logic [3:0] q;
  logic [3:0] qbar;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [3:0] hot_seq  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] cold_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  ring_counter #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .pre1    (pre1),
    .pre_234 (pre_234),
    .Q       (q),
    .Qbar    (qbar)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Checks Q and also that Qbar is its complement.
  task automatic chk_q(input string tag, input logic [3:0] exp);
    chk(tag, q, exp);
    chk({tag, "_bar"}, qbar, ~exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Resets the ring between clock edges.
  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    chk_q("rst_pulse", 4'b0000);
    rst = 1'b0;
    #1;
  endtask

  task automatic pulse_pre1();
    pre1 = 1'b1;
    #1;
    pre1 = 1'b0;
    #1;
  endtask

  task automatic pulse_pre234();
    pre_234 = 1'b1;
    #1;
    pre_234 = 1'b0;
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    pre1    = 1'b0;
    pre_234 = 1'b0;
    #1;

    // Reset acts immediately and holds through clock edges.
    rst = 1'b1;
    #1;
    chk_q("reset_now", 4'b0000);
    tick();
    chk_q("reset_hold1", 4'b0000);
    tick();
    chk_q("reset_hold2", 4'b0000);
    rst = 1'b0;
    #1;
    chk_q("reset_release", 4'b0000);

    // Lock-up state: 8 edges with every input low.
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef RING_COUNTER_SELF_START_EN
      chk_q($sformatf("lockup_%0d", k), hot_seq[k % 4]);
`else
      chk_q($sformatf("lockup_%0d", k), 4'b0000);
`endif
    end

    // One-hot rotation.
    rst_pulse();
    pulse_pre1();
    chk_q("hot_seed", 4'b0001);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_q($sformatf("hot_rot_%0d", k), hot_seq[k % 4]);
    end

    // Reset between edges while Q=0100, then re-seed.
    tick();
    tick();
    chk_q("mid_pre", 4'b0100);
    rst = 1'b1;
    #1;
    chk_q("mid_rst", 4'b0000);
    tick();
    chk_q("mid_rst_hold", 4'b0000);
    rst = 1'b0;
    #1;
    pulse_pre1();
    chk_q("reseed", 4'b0001);
    tick();
    chk_q("reseed_rot1", 4'b0010);
    tick();
    chk_q("reseed_rot2", 4'b0100);

    // One-cold rotation.
    rst_pulse();
    pulse_pre234();
    chk_q("cold_seed", 4'b1110);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_q($sformatf("cold_rot_%0d", k), cold_seq[k % 4]);
    end

    // Mixed seed: 0001 plus pre_234 gives 1111, which rotates to itself.
    rst_pulse();
    pulse_pre1();
    pulse_pre234();
    chk_q("mix_all", 4'b1111);
    tick();
    chk_q("mix_all_rot", 4'b1111);

    // Mixed seed: 0010 plus pre_234 gives 1110.
    rst_pulse();
    pulse_pre1();
    tick();
    chk_q("mix_base", 4'b0010);
    pulse_pre234();
    chk_q("mix_cold", 4'b1110);
    tick();
    chk_q("mix_cold_rot", 4'b1101);

    // pre1 held across an edge: FF1 is held at 1 while FF2..FF4 still shift.
    rst_pulse();
    pre1 = 1'b1;
    #1;
    chk_q("pre1_held", 4'b0001);
    tick();
    chk_q("pre1_held_edge", 4'b0011);
    pre1 = 1'b0;
    #1;
    tick();
    chk_q("pre1_release_rot", 4'b0110);

    // pre_234 held across an edge: FF1 shifts while FF2..FF4 are held at 1.
    rst_pulse();
    pre_234 = 1'b1;
    #1;
    chk_q("pre234_held", 4'b1110);
    tick();
    chk_q("pre234_held_edge", 4'b1111);
    pre_234 = 1'b0;
    #1;

    // Reset takes priority over both presets.
    rst  = 1'b1;
    pre1 = 1'b1;
    pre_234 = 1'b1;
    #1;
    chk_q("rst_over_pre", 4'b0000);
    tick();
    chk_q("rst_over_pre_edge", 4'b0000);
    pre1    = 1'b0;
    pre_234 = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk_q("final_clear", 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
